grf: RTL and testbench

//  General register file at the write-back end of the 5-stage pipeline.

---
 rtl/cpu_defs.sv | 33 +++
 rtl/grf_if.sv | 29 ++
 rtl/grf_read_port.sv | 21 ++
 rtl/grf.sv | 89 ++++++++
 tb/tb_grf.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: register aliases, default widths and the W-stage
// selector encodings that feed the register file.
package cpu_defs;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } regDst_e;

  typedef enum logic [1:0] {
    MEMTOR_ALU = 2'b00,
    MEMTOR_DM  = 2'b01,
    MEMTOR_EXT = 2'b10,
    MEMTOR_PC8 = 2'b11
  } memToR_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [ADDR_W_DEF-1:0]  addr;
    logic [DATA_W_DEF-1:0]  data;
  } traceEntry_t;

  // $0 is hard-wired, so only non-zero destinations commit.
  function automatic logic isCommit(input logic we, input logic [ADDR_W_DEF-1:0] a3);
    return we && (a3 != REG_ZERO);
  endfunction
endpackage

// File: rtl/grf_if.sv
// Register file bus: two D-stage read ports, the W-stage write port and
// the registered write trace.
interface grf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              we;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD;
  logic [31:0]       W_pc;
  logic              trace_valid;
  logic [31:0]       trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;

  modport slave (
    input  A1, A2, we, A3, WD, W_pc,
    output RD1, RD2, trace_valid, trace_pc, trace_addr, trace_data
  );

  modport master (
    output A1, A2, we, A3, WD, W_pc,
    input  RD1, RD2, trace_valid, trace_pc, trace_addr, trace_data
  );
endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: $0 forcing, optional W->D bypass, array select.
module grf_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wAddr,
  input  logic [DATA_W-1:0]            wData,
  input  logic [DEPTH-1:0][DATA_W-1:0] regView,
  output logic [DATA_W-1:0]            rd
);
  always_comb begin
    rd = regView[addr];
    if (BYPASS && we && (wAddr == addr)) rd = wData;
    // $0 wins over bypass: a write aimed at $0 never becomes visible.
    if (addr == '0) rd = '0;
  end
endmodule

// File: rtl/grf.sv
// General register file: 2**ADDR_W x DATA_W, $0 hard-wired, two bypassed
// combinational read ports and a one-cycle write trace.
module grf
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic reset,
  grf_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NPORTS = 2;

  logic [DATA_W-1:0]            mem [1:DEPTH-1];
  logic [DEPTH-1:0][DATA_W-1:0] regView;
  logic                         commit;

  logic                         traceValid;
  logic [31:0]                  tracePc;
  logic [ADDR_W-1:0]            traceAddr;
  logic [DATA_W-1:0]            traceData;

  assign commit = bus.we && (bus.A3 != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[bus.A3] <= bus.WD;
    end
  end

  // Slot 0 is a constant so the read ports can index uniformly.
  always_comb begin
    regView = '0;
    for (int i = 1; i < DEPTH; i++) regView[i] = mem[i];
  end

  logic [NPORTS-1:0][ADDR_W-1:0] rAddr;
  logic [NPORTS-1:0][DATA_W-1:0] rData;

  assign rAddr = {bus.A2, bus.A1};

  generate
    for (genvar p = 0; p < NPORTS; p++) begin : gPort
      grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
      ) uPort (
        .addr    (rAddr[p]),
        .we      (bus.we),
        .wAddr   (bus.A3),
        .wData   (bus.WD),
        .regView (regView),
        .rd      (rData[p])
      );
    end
  endgenerate

  assign bus.RD1 = rData[0];
  assign bus.RD2 = rData[1];

  // Fields hold between commits; only the valid strobe drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      traceValid <= 1'b0;
      tracePc    <= '0;
      traceAddr  <= '0;
      traceData  <= '0;
    end else begin
      traceValid <= commit;
      if (commit) begin
        tracePc   <= bus.W_pc;
        traceAddr <= bus.A3;
        traceData <= bus.WD;
      end
    end
  end

  assign bus.trace_valid = traceValid;
  assign bus.trace_pc    = tracePc;
  assign bus.trace_addr  = traceAddr;
  assign bus.trace_data  = traceData;
endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed cases then a random regression,
// run against a bypassing and a non-bypassing instance in parallel.
module tb_grf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        tWe;
  logic [4:0]  tA1, tA2, tA3;
  logic [31:0] tWd, tPc;

  grf_if #(.DATA_W(32), .ADDR_W(5)) ifB ();
  grf_if #(.DATA_W(32), .ADDR_W(5)) ifN ();

  assign ifB.we = tWe;  assign ifN.we = tWe;
  assign ifB.A1 = tA1;  assign ifN.A1 = tA1;
  assign ifB.A2 = tA2;  assign ifN.A2 = tA2;
  assign ifB.A3 = tA3;  assign ifN.A3 = tA3;
  assign ifB.WD = tWd;  assign ifN.WD = tWd;
  assign ifB.W_pc = tPc; assign ifN.W_pc = tPc;

  grf #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dutB (.clk(clk), .reset(reset), .bus(ifB.slave));
  grf #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dutN (.clk(clk), .reset(reset), .bus(ifN.slave));

  // Reference: plain array of register contents plus the last trace tuple.
  logic [31:0] refMem [32];
  logic        expTv;
  logic [31:0] expPc, expData;
  logic [4:0]  expAddr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && tWe && tA3 == a) return tWd;
    return refMem[a];
  endfunction

  task automatic refReset();
    for (int i = 0; i < 32; i++) refMem[i] = 32'd0;
    expTv = 1'b0; expPc = '0; expAddr = '0; expData = '0;
  endtask

  task automatic setIn(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    tWe = we; tA1 = a1; tA2 = a2; tA3 = a3; tWd = wd; tPc = pc;
  endtask

  task automatic checkReads(input string tag);
    #1;
    chk({tag, ".rd1B"}, ifB.RD1, refRead(tA1, 1'b1));
    chk({tag, ".rd2B"}, ifB.RD2, refRead(tA2, 1'b1));
    chk({tag, ".rd1N"}, ifN.RD1, refRead(tA1, 1'b0));
    chk({tag, ".rd2N"}, ifN.RD2, refRead(tA2, 1'b0));
  endtask

  task automatic checkTrace(input string tag);
    chk({tag, ".tvB"},   ifB.trace_valid, expTv);
    chk({tag, ".tpcB"},  ifB.trace_pc,    expPc);
    chk({tag, ".taB"},   ifB.trace_addr,  expAddr);
    chk({tag, ".tdB"},   ifB.trace_data,  expData);
    chk({tag, ".tvN"},   ifN.trace_valid, expTv);
    chk({tag, ".tdN"},   ifN.trace_data,  expData);
  endtask

  // Advance one edge, apply the write rule to the model, check the trace.
  task automatic stepClk(input string tag);
    @(posedge clk);
    #1;
    if (tWe && tA3 != 5'd0) begin
      refMem[tA3] = tWd;
      expTv = 1'b1; expPc = tPc; expAddr = tA3; expData = tWd;
    end else begin
      expTv = 1'b0;
    end
    checkTrace(tag);
  endtask

  initial begin
    refReset();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    #12;
    chk("rst.tv", ifB.trace_valid, 1'b0);
    checkReads("rst");
    @(negedge clk);
    reset = 1'b0;

    // Same-cycle bypass of a write to $8.
    setIn(1'b1, 5'd8, 5'd0, 5'd8, 32'hDEADBEEF, 32'h0000_3100);
    checkReads("byp8.pre");
    stepClk("byp8");
    chk("byp8.addr", ifB.trace_addr, 5'd8);
    setIn(1'b0, 5'd8, 5'd8, 5'd8, 32'h0, 32'h0);
    checkReads("byp8.post");

    // $0 writes are invisible and untraced.
    setIn(1'b1, 5'd0, 5'd8, 5'd0, 32'h1234, 32'h0000_3200);
    checkReads("zero.pre");
    stepClk("zero");
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    checkReads("zero.post");

    // Back-to-back writes to $31, one trace per write.
    setIn(1'b1, 5'd0, 5'd31, 5'd31, 32'h3008, 32'h3000);
    stepClk("ra1");
    setIn(1'b1, 5'd0, 5'd31, 5'd31, 32'h300C, 32'h3004);
    stepClk("ra2");
    setIn(1'b0, 5'd0, 5'd31, 5'd31, 32'h0, 32'h0);
    checkReads("ra.final");
    chk("ra.rd2", ifB.RD2, 32'h300C);

    // Both ports on $5 with a same-cycle write; old value first.
    setIn(1'b1, 5'd0, 5'd0, 5'd5, 32'h11, 32'h3300);
    stepClk("r5.init");
    setIn(1'b1, 5'd5, 5'd5, 5'd5, 32'h55, 32'h3304);
    checkReads("r5.pre");
    chk("r5.nbyp", ifN.RD1, 32'h11);
    stepClk("r5");
    setIn(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0);
    checkReads("r5.post");

    // Fill some registers, then reset mid-cycle with a write pending.
    for (int i = 1; i < 32; i++) begin
      setIn(1'b1, 5'd0, 5'd0, 5'(i), 32'hA000_0000 + 32'(i), 32'(i * 4));
      stepClk("fill");
    end
    setIn(1'b1, 5'd3, 5'd4, 5'd3, 32'h77, 32'h4000);
    #2;
    reset = 1'b1;
    refReset();
    @(posedge clk);
    #1;
    chk("rst.mid.tvB", ifB.trace_valid, 1'b0);
    chk("rst.mid.tvN", ifN.trace_valid, 1'b0);
    tWe = 1'b0;
    for (int a = 1; a < 32; a++) begin
      tA1 = 5'(a); tA2 = 5'(32 - a);
      checkReads("rst.mid");
      chk("rst.mid.tv", ifB.trace_valid, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    setIn(1'b0, 5'd3, 5'd31, 5'd0, 32'h0, 32'h0);
    checkReads("rst.after");
    checkTrace("rst.after");

    // Random regression.
    for (int c = 0; c < 10000; c++) begin
      setIn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom, $urandom);
      // Bias toward reads hitting the write index to exercise bypass.
      if ($urandom_range(0, 3) == 0) tA1 = tA3;
      if ($urandom_range(0, 3) == 0) tA2 = tA3;
      checkReads("rnd");
      stepClk("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
